fifo_uart_tx: RTL

- Downstream drain stage for the 8-deep byte FIFO.
- Pops bytes through the FIFO's rd/empty/data_out interface and serializes each one as an asynchronous UART frame on a single tx line: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Sits between the FIFO and the board-level serial pin; it is the only reader of the FIFO.

---
 rtl/fifo_uart_tx.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains an external byte FIFO: one registered read strobe per byte,
// then start bit, 8 data bits LSB first, optional parity and 1 or 2 stop bits on tx.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_PARITY = 3'd5;
  localparam logic [2:0] S_STOP   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          tx_q, tx_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;
  logic          start_ok;

  assign bit_end  = (baud_q == BAUD_LAST);
  assign start_ok = en && !fifo_empty;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    rd_d     = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (start_ok) begin
          state_d = S_FETCH;
          rd_d    = 1'b1;
        end
      end
      S_FETCH: state_d = S_WAIT;
      // fifo_data is valid now and is captured exactly once per frame
      S_WAIT: begin
        shift_d  = fifo_data;
        parity_d = (^fifo_data) ^ PARITY_ODD;
        tx_d     = 1'b0;
        baud_d   = '0;
        state_d  = S_START;
      end
      S_START: begin
        baud_d = baud_q + 1'b1;
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        baud_d = baud_q + 1'b1;
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
            if (PARITY_EN) begin
              tx_d    = parity_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        baud_d = baud_q + 1'b1;
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        baud_d = baud_q + 1'b1;
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d  = 3'd0;
            done_d = 1'b1;
            if (start_ok) begin
              state_d = S_FETCH;
              rd_d    = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign fifo_rd = rd_q;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule
